// File: rtl/header_insert_mb.sv
// AXI4-Stream header inserter: one meta word per packet becomes a multi-beat header,
// followed by the payload packet passed through unmodified, behind one output register.
module header_insert_mb #(
    parameter int TDATA_BYTES = 8,
    parameter int TKEEP_WIDTH = TDATA_BYTES,
    parameter int HDR_BYTES   = 12,
    parameter int TID_WIDTH   = 4,
    parameter int TDEST_WIDTH = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     target_tvalid,
    output logic                     target_tready,
    input  logic [8*TDATA_BYTES-1:0] target_tdata,
    input  logic [TKEEP_WIDTH-1:0]   target_tkeep,
    input  logic                     target_tlast,
    input  logic                     meta_tvalid,
    output logic                     meta_tready,
    input  logic [8*HDR_BYTES-1:0]   meta_tdata,
    input  logic [TID_WIDTH-1:0]     meta_tid,
    input  logic [TDEST_WIDTH-1:0]   meta_tdest,
    input  logic                     meta_hdr_only,
    output logic                     initiator_tvalid,
    input  logic                     initiator_tready,
    output logic [8*TDATA_BYTES-1:0] initiator_tdata,
    output logic [TKEEP_WIDTH-1:0]   initiator_tkeep,
    output logic                     initiator_tlast,
    output logic [TID_WIDTH-1:0]     initiator_tid,
    output logic [TDEST_WIDTH-1:0]   initiator_tdest,
    output logic                     initiator_tuser,
    output logic [CNT_WIDTH-1:0]     pkt_count
);

    localparam int TDATA_BITS = 8 * TDATA_BYTES;
    localparam int HDR_BEATS  = (HDR_BYTES + TDATA_BYTES - 1) / TDATA_BYTES;
    localparam int LAST_BYTES = HDR_BYTES - (HDR_BEATS - 1) * TDATA_BYTES;
    localparam int PAD_BITS   = TDATA_BITS * HDR_BEATS;
    localparam int BEAT_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

    localparam logic [TKEEP_WIDTH-1:0] KEEP_ALL  = '1;
    localparam logic [TKEEP_WIDTH-1:0] KEEP_LAST = KEEP_ALL >> (TKEEP_WIDTH - LAST_BYTES);
    localparam logic [BEAT_W-1:0]      BEAT_LAST = BEAT_W'(HDR_BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]             r_state;
    logic [PAD_BITS-1:0]    r_meta;
    logic [TID_WIDTH-1:0]   r_tid;
    logic [TDEST_WIDTH-1:0] r_tdest;
    logic                   r_hdr_only;
    logic [BEAT_W-1:0]      r_beat;

    logic                   r_tvalid;
    logic [TDATA_BITS-1:0]  r_tdata;
    logic [TKEEP_WIDTH-1:0] r_tkeep;
    logic                   r_tlast;
    logic                   r_tuser;
    logic [TID_WIDTH-1:0]   r_o_tid;
    logic [TDEST_WIDTH-1:0] r_o_tdest;
    logic [CNT_WIDTH-1:0]   r_pkt_count;

    logic                   w_adv;
    logic                   w_meta_hs;
    logic                   w_tgt_hs;
    logic                   w_hdr_last;
    logic [TDATA_BITS-1:0]  w_hdr_data;
    logic [TKEEP_WIDTH-1:0] w_hdr_keep;

    assign w_adv         = !r_tvalid || initiator_tready;
    assign meta_tready   = aresetn && (r_state == S_IDLE) && w_adv;
    assign target_tready = aresetn && (r_state == S_DATA) && w_adv;
    assign w_meta_hs     = meta_tvalid && meta_tready;
    assign w_tgt_hs      = target_tvalid && target_tready;

    // The meta word is zero-extended to whole beats, so bytes past the header read as 0.
    assign w_hdr_last = (r_beat == BEAT_LAST);
    assign w_hdr_data = r_meta[int'(r_beat) * TDATA_BITS +: TDATA_BITS];
    assign w_hdr_keep = w_hdr_last ? KEEP_LAST : KEEP_ALL;

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_meta      <= '0;
            r_tid       <= '0;
            r_tdest     <= '0;
            r_hdr_only  <= 1'b0;
            r_beat      <= '0;
            r_tvalid    <= 1'b0;
            r_tdata     <= '0;
            r_tkeep     <= '0;
            r_tlast     <= 1'b0;
            r_tuser     <= 1'b0;
            r_o_tid     <= '0;
            r_o_tdest   <= '0;
            r_pkt_count <= '0;
        end else begin
            if (r_tvalid && initiator_tready && r_tlast) begin
                r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
            end
            // A consumed beat is dropped unless a new beat is loaded below.
            if (w_adv) begin
                r_tvalid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_meta_hs) begin
                        r_meta     <= PAD_BITS'(meta_tdata);
                        r_tid      <= meta_tid;
                        r_tdest    <= meta_tdest;
                        r_hdr_only <= meta_hdr_only;
                        r_beat     <= '0;
                        r_state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_adv) begin
                        r_tvalid  <= 1'b1;
                        r_tdata   <= w_hdr_data;
                        r_tkeep   <= w_hdr_keep;
                        r_tlast   <= w_hdr_last && r_hdr_only;
                        r_tuser   <= 1'b1;
                        r_o_tid   <= r_tid;
                        r_o_tdest <= r_tdest;
                        r_beat    <= r_beat + BEAT_W'(1);
                        if (w_hdr_last) begin
                            r_state <= r_hdr_only ? S_IDLE : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tgt_hs) begin
                        r_tvalid  <= 1'b1;
                        r_tdata   <= target_tdata;
                        r_tkeep   <= target_tkeep;
                        r_tlast   <= target_tlast;
                        r_tuser   <= 1'b0;
                        r_o_tid   <= r_tid;
                        r_o_tdest <= r_tdest;
                        if (target_tlast) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign initiator_tvalid = r_tvalid;
    assign initiator_tdata  = r_tdata;
    assign initiator_tkeep  = r_tkeep;
    assign initiator_tlast  = r_tlast;
    assign initiator_tuser  = r_tuser;
    assign initiator_tid    = r_o_tid;
    assign initiator_tdest  = r_o_tdest;
    assign pkt_count        = r_pkt_count;

endmodule

// File: tb/tb_header_insert_mb.sv
// Scoreboard bench for header_insert_mb: randomized packets against a byte-level model,
// plus a directed single-beat-header check on a second instance.
module tb_header_insert_mb;

    localparam int DB = 4;
    localparam int HB = 6;
    localparam int NB = (HB + DB - 1) / DB;

    typedef struct packed {
        logic [47:0] data;
        logic [3:0]  tid;
        logic [3:0]  tdest;
        logic        hdr_only;
    } meta_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } pay_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
        logic [3:0]  tid;
        logic [3:0]  tdest;
    } beat_t;

    logic        a_clk = 1'b0;
    logic        a_rst_n = 1'b0;
    logic        a_target_tvalid = 1'b0;
    logic        a_target_tready;
    logic [31:0] a_target_tdata = '0;
    logic [3:0]  a_target_tkeep = '0;
    logic        a_target_tlast = 1'b0;
    logic        a_meta_tvalid = 1'b0;
    logic        a_meta_tready;
    logic [47:0] a_meta_tdata = '0;
    logic [3:0]  a_meta_tid = '0;
    logic [3:0]  a_meta_tdest = '0;
    logic        a_meta_hdr_only = 1'b0;
    logic        a_tvalid;
    logic        a_rdy = 1'b1;
    logic [31:0] a_tdata;
    logic [3:0]  a_tkeep;
    logic        a_tlast;
    logic [3:0]  a_tid;
    logic [3:0]  a_tdest;
    logic        a_tuser;
    logic [15:0] a_pkt_count;

    logic        b_rst_n = 1'b0;
    logic        b_target_tvalid = 1'b0;
    logic        b_target_tready;
    logic [63:0] b_target_tdata = '0;
    logic [7:0]  b_target_tkeep = '0;
    logic        b_target_tlast = 1'b0;
    logic        b_meta_tvalid = 1'b0;
    logic        b_meta_tready;
    logic [63:0] b_meta_tdata = '0;
    logic [3:0]  b_meta_tid = '0;
    logic [3:0]  b_meta_tdest = '0;
    logic        b_tvalid;
    logic [63:0] b_tdata;
    logic [7:0]  b_tkeep;
    logic        b_tlast;
    logic [3:0]  b_tid;
    logic [3:0]  b_tdest;
    logic        b_tuser;
    logic [31:0] b_pkt_count;

    header_insert_mb #(
        .TDATA_BYTES(DB), .TKEEP_WIDTH(DB), .HDR_BYTES(HB),
        .TID_WIDTH(4), .TDEST_WIDTH(4), .CNT_WIDTH(16)
    ) dut_a (
        .aclk(a_clk), .aresetn(a_rst_n),
        .target_tvalid(a_target_tvalid), .target_tready(a_target_tready),
        .target_tdata(a_target_tdata), .target_tkeep(a_target_tkeep),
        .target_tlast(a_target_tlast),
        .meta_tvalid(a_meta_tvalid), .meta_tready(a_meta_tready),
        .meta_tdata(a_meta_tdata), .meta_tid(a_meta_tid), .meta_tdest(a_meta_tdest),
        .meta_hdr_only(a_meta_hdr_only),
        .initiator_tvalid(a_tvalid), .initiator_tready(a_rdy),
        .initiator_tdata(a_tdata), .initiator_tkeep(a_tkeep),
        .initiator_tlast(a_tlast), .initiator_tid(a_tid), .initiator_tdest(a_tdest),
        .initiator_tuser(a_tuser), .pkt_count(a_pkt_count)
    );

    header_insert_mb #(
        .TDATA_BYTES(8), .TKEEP_WIDTH(8), .HDR_BYTES(8),
        .TID_WIDTH(4), .TDEST_WIDTH(4), .CNT_WIDTH(32)
    ) dut_b (
        .aclk(a_clk), .aresetn(b_rst_n),
        .target_tvalid(b_target_tvalid), .target_tready(b_target_tready),
        .target_tdata(b_target_tdata), .target_tkeep(b_target_tkeep),
        .target_tlast(b_target_tlast),
        .meta_tvalid(b_meta_tvalid), .meta_tready(b_meta_tready),
        .meta_tdata(b_meta_tdata), .meta_tid(b_meta_tid), .meta_tdest(b_meta_tdest),
        .meta_hdr_only(1'b0),
        .initiator_tvalid(b_tvalid), .initiator_tready(1'b1),
        .initiator_tdata(b_tdata), .initiator_tkeep(b_tkeep),
        .initiator_tlast(b_tlast), .initiator_tid(b_tid), .initiator_tdest(b_tdest),
        .initiator_tuser(b_tuser), .pkt_count(b_pkt_count)
    );

    initial forever #5 a_clk = ~a_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    meta_t meta_q[$];
    pay_t  pay_q[$];
    beat_t exp_q[$];
    pay_t  pay_list[$];

    int meta_gap = 0;
    int pay_gap  = 0;
    int rdy_pct  = 100;

    // Reference model: header bytes laid out little-endian across beats, then payload as-is.
    task automatic add_packet(input logic [47:0] md, input logic [3:0] tid,
                              input logic [3:0] tdest, input logic ho);
        beat_t b;
        meta_q.push_back('{data: md, tid: tid, tdest: tdest, hdr_only: ho});
        for (int k = 0; k < NB; k++) begin
            b = '0;
            for (int j = 0; j < DB; j++) begin
                if (k * DB + j < HB) begin
                    b.data[8*j +: 8] = md[8*(k*DB+j) +: 8];
                    b.keep[j] = 1'b1;
                end
            end
            b.last  = (k == NB - 1) && ho;
            b.user  = 1'b1;
            b.tid   = tid;
            b.tdest = tdest;
            exp_q.push_back(b);
        end
        if (!ho) begin
            foreach (pay_list[i]) begin
                pay_q.push_back(pay_list[i]);
                exp_q.push_back('{data: pay_list[i].data, keep: pay_list[i].keep,
                                  last: pay_list[i].last, user: 1'b0, tid: tid, tdest: tdest});
            end
        end
        pay_list.delete();
    endtask

    task automatic rand_payload(input int n);
        for (int i = 0; i < n; i++)
            pay_list.push_back('{data: $urandom, keep: 4'($urandom_range(1, 15)), last: (i == n - 1)});
    endtask

    function automatic logic [47:0] rand_meta();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[47:0];
    endfunction

    initial begin : meta_driver
        logic hs;
        forever begin
            @(negedge a_clk);
            hs = a_meta_tvalid && a_meta_tready;
            @(posedge a_clk);
            #1;
            if (hs && meta_q.size() > 0) begin
                void'(meta_q.pop_front());
                a_meta_tvalid = 1'b0;
            end
            if (!a_meta_tvalid && meta_q.size() > 0 && $urandom_range(99) >= meta_gap) begin
                a_meta_tvalid   = 1'b1;
                a_meta_tdata    = meta_q[0].data;
                a_meta_tid      = meta_q[0].tid;
                a_meta_tdest    = meta_q[0].tdest;
                a_meta_hdr_only = meta_q[0].hdr_only;
            end
        end
    end

    initial begin : pay_driver
        logic hs;
        forever begin
            @(negedge a_clk);
            hs = a_target_tvalid && a_target_tready;
            @(posedge a_clk);
            #1;
            if (hs && pay_q.size() > 0) begin
                void'(pay_q.pop_front());
                a_target_tvalid = 1'b0;
            end
            if (!a_target_tvalid && pay_q.size() > 0 && $urandom_range(99) >= pay_gap) begin
                a_target_tvalid = 1'b1;
                a_target_tdata  = pay_q[0].data;
                a_target_tkeep  = pay_q[0].keep;
                a_target_tlast  = pay_q[0].last;
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge a_clk);
            #1;
            a_rdy = ($urandom_range(99) < rdy_pct);
        end
    end

    logic        stall = 1'b0;
    beat_t       held;
    logic [15:0] exp_cnt = '0;
    logic        armed = 1'b0;
    logic        tight = 1'b0;
    int          gap = 0;
    logic        hdr_phase = 1'b0;
    logic        tr_seen = 1'b0;

    initial begin : monitor
        beat_t act, e;
        forever begin
            @(negedge a_clk);
            if (!a_rst_n) begin
                stall   = 1'b0;
                armed   = 1'b0;
                exp_cnt = '0;
            end else begin
                if (hdr_phase) tr_seen = tr_seen | a_target_tready;
                act = '{data: a_tdata, keep: a_tkeep, last: a_tlast, user: a_tuser,
                        tid: a_tid, tdest: a_tdest};
                if (stall) check("stall_hold", {a_tvalid, act}, {1'b1, held});
                if (a_tvalid && a_rdy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat_queue_size", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", act, e);
                        check("pkt_count_at_beat", a_pkt_count, exp_cnt);
                        if (armed && tight) check("bubble_cycles", gap, 1);
                        armed = 1'b0;
                        if (e.last) begin
                            exp_cnt = exp_cnt + 16'd1;
                            armed   = 1'b1;
                            gap     = 0;
                        end
                    end
                    stall = 1'b0;
                end else begin
                    if (!a_tvalid) gap++;
                    stall = a_tvalid;
                    held  = act;
                end
            end
        end
    end

    task automatic drain(input string name, input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || meta_q.size() != 0 || pay_q.size() != 0) && c < budget) begin
            @(posedge a_clk);
            c++;
        end
        check({name, "_drain_in_budget"}, (c < budget), 1);
        repeat (3) @(posedge a_clk);
        #1;
    endtask

    initial begin : main
        int c;
        logic [63:0] bd [2];
        logic [7:0]  bk [2];
        logic [1:0]  bf [2];
        logic [3:0]  bt [2];
        int nb;
        logic mhs, ths;

        repeat (3) @(posedge a_clk);
        #1;
        check("reset_tvalid", a_tvalid, 0);
        check("reset_data_keep_last_user", {a_tdata, a_tkeep, a_tlast, a_tuser}, 0);
        check("reset_tid_tdest", {a_tid, a_tdest}, 0);
        check("reset_pkt_count", a_pkt_count, 0);
        check("reset_readies", {a_meta_tready, a_target_tready}, 0);
        @(negedge a_clk);
        a_rst_n = 1'b1;

        // Directed multi-beat header with a two-beat payload.
        pay_list.push_back('{data: 32'hAABBCCDD, keep: 4'hF, last: 1'b0});
        pay_list.push_back('{data: 32'h11223344, keep: 4'hF, last: 1'b1});
        add_packet(48'h665544332211, 4'd1, 4'd2, 1'b0);
        drain("directed", 200);
        check("pkt_count_after_directed", a_pkt_count, 1);

        // Header-only packet: the payload side must never be offered ready.
        tr_seen   = 1'b0;
        hdr_phase = 1'b1;
        add_packet(48'h665544332211, 4'd1, 4'd2, 1'b1);
        drain("hdr_only", 200);
        hdr_phase = 1'b0;
        check("hdr_only_target_tready_seen", tr_seen, 0);
        check("hdr_only_back_in_idle", a_meta_tready, 1);
        check("pkt_count_after_hdr_only", a_pkt_count, 2);

        // Back-to-back preloaded packets with a single bubble between them.
        armed = 1'b0;
        tight = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            rand_payload(2);
            add_packet(rand_meta(), 4'(i), 4'(i + 4), 1'b0);
        end
        drain("back_to_back", 300);
        tight = 1'b0;
        check("pkt_count_after_b2b", a_pkt_count, 5);

        // Random traffic with gaps and backpressure.
        rdy_pct  = 70;
        meta_gap = 30;
        pay_gap  = 30;
        for (int i = 0; i < 40; i++) begin
            logic ho;
            ho = ($urandom_range(3) == 0);
            if (!ho) rand_payload($urandom_range(1, 4));
            add_packet(rand_meta(), 4'($urandom), 4'($urandom), ho);
        end
        drain("random", 6000);
        check("pkt_count_after_random", a_pkt_count, 45);

        // Reset while payload is on the output.
        rdy_pct  = 100;
        meta_gap = 0;
        pay_gap  = 0;
        rand_payload(3);
        add_packet(rand_meta(), 4'd9, 4'd10, 1'b0);
        c = 0;
        while (!(a_tvalid && !a_tuser) && c < 200) begin
            @(negedge a_clk);
            c++;
        end
        check("reached_payload_in_budget", (c < 200), 1);
        @(posedge a_clk);
        #3;
        a_rst_n = 1'b0;
        meta_q.delete();
        pay_q.delete();
        exp_q.delete();
        a_meta_tvalid   = 1'b0;
        a_target_tvalid = 1'b0;
        #1;
        check("midreset_outputs_zero",
              {a_tvalid, a_tdata, a_tkeep, a_tlast, a_tuser, a_tid, a_tdest}, 0);
        check("midreset_pkt_count", a_pkt_count, 0);
        check("midreset_readies", {a_meta_tready, a_target_tready}, 0);
        repeat (2) @(posedge a_clk);
        @(negedge a_clk);
        a_rst_n = 1'b1;
        rand_payload(2);
        add_packet(rand_meta(), 4'd3, 4'd4, 1'b0);
        drain("after_reset", 200);
        check("pkt_count_after_reset_pkt", a_pkt_count, 1);

        // Single-beat header on the 8-byte instance, payload offered early.
        @(negedge a_clk);
        b_rst_n = 1'b1;
        @(posedge a_clk);
        #1;
        b_meta_tdata    = 64'h8877665544332211;
        b_meta_tid      = 4'd3;
        b_meta_tdest    = 4'd5;
        b_meta_tvalid   = 1'b1;
        b_target_tdata  = 64'hDEADBEEFCAFEF00D;
        b_target_tkeep  = 8'hFF;
        b_target_tlast  = 1'b1;
        b_target_tvalid = 1'b1;
        nb = 0;
        c  = 0;
        while (nb < 2 && c < 50) begin
            @(negedge a_clk);
            mhs = b_meta_tvalid && b_meta_tready;
            ths = b_target_tvalid && b_target_tready;
            if (b_tvalid) begin
                bd[nb] = b_tdata;
                bk[nb] = b_tkeep;
                bf[nb] = {b_tuser, b_tlast};
                bt[nb] = b_tid;
                nb++;
            end
            @(posedge a_clk);
            #1;
            if (mhs) b_meta_tvalid = 1'b0;
            if (ths) b_target_tvalid = 1'b0;
            c++;
        end
        check("single_hdr_beats_seen", nb, 2);
        if (nb == 2) begin
            check("single_hdr_beat0", {bd[0], bk[0], bf[0], bt[0]},
                  {64'h8877665544332211, 8'hFF, 2'b10, 4'd3});
            check("single_hdr_beat1", {bd[1], bk[1], bf[1], bt[1]},
                  {64'hDEADBEEFCAFEF00D, 8'hFF, 2'b01, 4'd3});
        end
        @(posedge a_clk);
        #1;
        check("single_hdr_pkt_count", b_pkt_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
